// File: rtl/logic_fu_arbiter_if.sv
`default_nettype none
// ============================================================================
// logic_fu_arbiter_if : request bus (NUM_REQ requesters) and result handshake
// Revision 1.0
// ============================================================================
interface logic_fu_arbiter_if #(
   parameter int NUM_REQ = 4,
   parameter int WIDTH   = 64,
   parameter int TAG_W   = 6
);
   logic [NUM_REQ-1:0]       req_valid;
   logic [NUM_REQ-1:0]       req_ready;
   logic [2*NUM_REQ-1:0]     req_op;
   logic [WIDTH*NUM_REQ-1:0] req_a;
   logic [WIDTH*NUM_REQ-1:0] req_b;
   logic [TAG_W*NUM_REQ-1:0] req_tag;

   logic                     res_valid;
   logic                     res_ready;
   logic [WIDTH-1:0]         res_data;
   logic [TAG_W-1:0]         res_tag;

   modport slave (
      input  req_valid, req_op, req_a, req_b, req_tag, res_ready,
      output req_ready, res_valid, res_data, res_tag
   );

   modport master (
      output req_valid, req_op, req_a, req_b, req_tag, res_ready,
      input  req_ready, res_valid, res_data, res_tag
   );
endinterface
`default_nettype wire

// File: rtl/logic_fu_arbiter.sv
`default_nettype none
// ============================================================================
// logic_fu_arbiter : round-robin shared AND/OR/XOR/NOR unit, one-entry result reg
// Revision 1.0
// ============================================================================
module logic_fu_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int WIDTH   = 64,
   parameter int TAG_W   = 6,
   parameter int CNT_W   = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   logic_fu_arbiter_if.slave    bus,
   input  logic                 flush,
   output logic                 busy,
   output logic [CNT_W-1:0]     issue_cnt
);
   localparam int               PTR_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam logic [PTR_W-1:0] C_LAST   = PTR_W'(NUM_REQ - 1);
   localparam logic [1:0]       C_OP_AND = 2'b00;
   localparam logic [1:0]       C_OP_OR  = 2'b01;
   localparam logic [1:0]       C_OP_XOR = 2'b10;

   logic [PTR_W-1:0] r_rr_ptr;
   logic             r_res_valid;
   logic [WIDTH-1:0] r_res_data;
   logic [TAG_W-1:0] r_res_tag;
   logic [CNT_W-1:0] r_issue_cnt;

   logic               w_accept_en;
   logic               w_found;
   logic               w_accept;
   logic [PTR_W-1:0]   w_gnt_idx;
   logic [NUM_REQ-1:0] w_grant;
   logic [1:0]         w_op  [NUM_REQ];
   logic [WIDTH-1:0]   w_a   [NUM_REQ];
   logic [WIDTH-1:0]   w_b   [NUM_REQ];
   logic [TAG_W-1:0]   w_tag [NUM_REQ];
   logic [WIDTH-1:0]   w_sel_a;
   logic [WIDTH-1:0]   w_sel_b;
   logic [WIDTH-1:0]   w_result;

   generate
      for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
         assign w_op[i]  = bus.req_op[2*i +: 2];
         assign w_a[i]   = bus.req_a[WIDTH*i +: WIDTH];
         assign w_b[i]   = bus.req_b[WIDTH*i +: WIDTH];
         assign w_tag[i] = bus.req_tag[TAG_W*i +: TAG_W];
      end
   endgenerate

   // Reset gates the grant so nothing is offered while the result register is cleared.
   assign w_accept_en = !reset && !flush && (!r_res_valid || bus.res_ready);

   always_comb begin
      int idx;
      w_found   = 1'b0;
      w_gnt_idx = '0;
      idx       = 0;
      for (int k = 0; k < NUM_REQ; k++) begin
         idx = (int'(r_rr_ptr) + k) % NUM_REQ;
         if (!w_found && bus.req_valid[PTR_W'(idx)]) begin
            w_found   = 1'b1;
            w_gnt_idx = PTR_W'(idx);
         end
      end
   end

   assign w_accept = w_accept_en && w_found;

   always_comb begin
      w_grant = '0;
      if (w_accept) begin
         w_grant[w_gnt_idx] = 1'b1;
      end
   end

   assign w_sel_a = w_a[w_gnt_idx];
   assign w_sel_b = w_b[w_gnt_idx];

   always_comb begin
      case (w_op[w_gnt_idx])
         C_OP_AND: w_result = w_sel_a & w_sel_b;
         C_OP_OR:  w_result = w_sel_a | w_sel_b;
         C_OP_XOR: w_result = w_sel_a ^ w_sel_b;
         default:  w_result = ~(w_sel_a | w_sel_b);
      endcase
   end

   // Accept takes priority over drain, so a same-edge drain and reload leaves no bubble.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_res_valid <= 1'b0;
         r_res_data  <= '0;
         r_res_tag   <= '0;
      end else if (flush) begin
         r_res_valid <= 1'b0;
      end else if (w_accept) begin
         r_res_valid <= 1'b1;
         r_res_data  <= w_result;
         r_res_tag   <= w_tag[w_gnt_idx];
      end else if (r_res_valid && bus.res_ready) begin
         r_res_valid <= 1'b0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_rr_ptr <= '0;
      end else if (w_accept) begin
         r_rr_ptr <= (w_gnt_idx == C_LAST) ? '0 : w_gnt_idx + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_issue_cnt <= '0;
      end else if (w_accept && (r_issue_cnt != '1)) begin
         r_issue_cnt <= r_issue_cnt + 1'b1;
      end
   end

   assign bus.req_ready = w_grant;
   assign bus.res_valid = r_res_valid;
   assign bus.res_data  = r_res_data;
   assign bus.res_tag   = r_res_tag;
   assign busy          = r_res_valid && !bus.res_ready;
   assign issue_cnt     = r_issue_cnt;

endmodule
`default_nettype wire

// File: tb/tb_logic_fu_arbiter.sv
`default_nettype none
// ============================================================================
// tb_logic_fu_arbiter : directed + randomized checks against a cycle-level model
// Revision 1.0
// ============================================================================
module tb_logic_fu_arbiter;
   localparam int NUM_REQ = 4;
   localparam int WIDTH   = 64;
   localparam int TAG_W   = 6;
   localparam int CNT_W   = 6;
   localparam int CNT_MAX = (1 << CNT_W) - 1;

   logic             clk = 1'b0;
   logic             reset;
   logic             flush;
   logic             busy;
   logic [CNT_W-1:0] issue_cnt;

   logic_fu_arbiter_if #(.NUM_REQ(NUM_REQ), .WIDTH(WIDTH), .TAG_W(TAG_W)) bus ();

   logic_fu_arbiter #(
      .NUM_REQ (NUM_REQ),
      .WIDTH   (WIDTH),
      .TAG_W   (TAG_W),
      .CNT_W   (CNT_W)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .bus       (bus.slave),
      .flush     (flush),
      .busy      (busy),
      .issue_cnt (issue_cnt)
   );

   always #5 clk = ~clk;

   int               n_tests = 0;
   int               n_fail  = 0;
   int               m_ptr;
   bit               m_valid;
   logic [WIDTH-1:0] m_data;
   logic [TAG_W-1:0] m_tag;
   int               m_cnt;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [WIDTH-1:0] fu(input logic [1:0] op, input logic [WIDTH-1:0] a,
                                          input logic [WIDTH-1:0] b);
      case (op)
         2'b00:   return a & b;
         2'b01:   return a | b;
         2'b10:   return a ^ b;
         default: return ~(a | b);
      endcase
   endfunction

   // First valid requester in rotated order starting at the pointer, or -1.
   function automatic int model_grant();
      if (flush || (m_valid && !bus.res_ready)) return -1;
      for (int k = 0; k < NUM_REQ; k++) begin
         int idx;
         idx = (m_ptr + k) % NUM_REQ;
         if (bus.req_valid[idx]) return idx;
      end
      return -1;
   endfunction

   task automatic model_clear();
      m_valid = 1'b0;
      m_data  = '0;
      m_tag   = '0;
      m_ptr   = 0;
      m_cnt   = 0;
   endtask

   task automatic drive(input logic [NUM_REQ-1:0] v, input logic [2*NUM_REQ-1:0] ops,
                        input logic rdy, input logic fl);
      bus.req_valid = v;
      bus.req_op    = ops;
      bus.res_ready = rdy;
      flush         = fl;
   endtask

   task automatic set_all(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input int tag_base);
      for (int i = 0; i < NUM_REQ; i++) begin
         bus.req_a[WIDTH*i +: WIDTH]   = a;
         bus.req_b[WIDTH*i +: WIDTH]   = b;
         bus.req_tag[TAG_W*i +: TAG_W] = TAG_W'(tag_base + i);
      end
   endtask

   task automatic set_random_operands();
      for (int i = 0; i < NUM_REQ; i++) begin
         bus.req_a[WIDTH*i +: WIDTH]   = {$urandom, $urandom};
         bus.req_b[WIDTH*i +: WIDTH]   = {$urandom, $urandom};
         bus.req_tag[TAG_W*i +: TAG_W] = TAG_W'($urandom);
      end
   endtask

   // One clock: check outputs at the falling edge, advance the model at the rising edge.
   task automatic cycle();
      int g;
      logic [NUM_REQ-1:0] eg;
      @(negedge clk);
      g  = model_grant();
      eg = '0;
      if (g >= 0) eg[g] = 1'b1;
      check_eq("req_ready", bus.req_ready, eg);
      check_eq("res_valid", bus.res_valid, m_valid);
      if (m_valid) begin
         check_eq("res_data", bus.res_data, m_data);
         check_eq("res_tag", bus.res_tag, m_tag);
      end
      check_eq("busy", busy, m_valid && !bus.res_ready);
      check_eq("issue_cnt", issue_cnt, m_cnt);
      @(posedge clk);
      if (flush) begin
         m_valid = 1'b0;
      end else if (g >= 0) begin
         m_valid = 1'b1;
         m_data  = fu(bus.req_op[2*g +: 2], bus.req_a[WIDTH*g +: WIDTH], bus.req_b[WIDTH*g +: WIDTH]);
         m_tag   = bus.req_tag[TAG_W*g +: TAG_W];
         m_ptr   = (g + 1) % NUM_REQ;
         if (m_cnt < CNT_MAX) m_cnt++;
      end else if (m_valid && bus.res_ready) begin
         m_valid = 1'b0;
      end
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      model_clear();
      @(posedge clk);
      #1 reset = 1'b0;
   endtask

   logic [WIDTH-1:0] exp_t2 [4];

   initial begin
      reset = 1'b1;
      model_clear();
      drive('1, '0, 1'b1, 1'b0);
      set_all('0, '0, 0);

      // Reset state, with every requester asking
      @(negedge clk);
      check_eq("rst res_valid", bus.res_valid, 1'b0);
      check_eq("rst res_data", bus.res_data, '0);
      check_eq("rst res_tag", bus.res_tag, '0);
      check_eq("rst issue_cnt", issue_cnt, '0);
      check_eq("rst req_ready", bus.req_ready, '0);
      @(posedge clk);
      #1 reset = 1'b0;

      // Test 1: single NOR request
      set_all(64'h5555_5555_5555_5555, 64'hAAAA_AAAA_AAAA_AAAA, 5);
      drive(4'b0001, 8'b0000_0011, 1'b1, 1'b0);
      cycle();
      drive('0, '0, 1'b1, 1'b0);
      check_eq("t1 res_valid", bus.res_valid, 1'b1);
      check_eq("t1 res_data", bus.res_data, 64'h0);
      check_eq("t1 res_tag", bus.res_tag, 64'd5);
      check_eq("t1 issue_cnt", issue_cnt, 64'd1);
      cycle();

      // Test 2: full round-robin, back-to-back
      do_reset();
      exp_t2[0] = 64'h0F00_0F00_0F00_0F00;
      exp_t2[1] = 64'hFF0F_FF0F_FF0F_FF0F;
      exp_t2[2] = 64'hF00F_F00F_F00F_F00F;
      exp_t2[3] = 64'h00F0_00F0_00F0_00F0;
      set_all(64'hFF00_FF00_FF00_FF00, 64'h0F0F_0F0F_0F0F_0F0F, 10);
      drive(4'b1111, 8'b11_10_01_00, 1'b1, 1'b0);
      for (int c = 0; c < 5; c++) begin
         cycle();
         check_eq("t2 res_valid", bus.res_valid, 1'b1);
         check_eq("t2 res_data", bus.res_data, exp_t2[c % 4]);
         check_eq("t2 res_tag", bus.res_tag, 64'(10 + (c % 4)));
      end

      // Test 3: stall with requesters 1 and 2 waiting, then same-edge drain+accept
      drive(4'b0010, 8'b11_10_01_00, 1'b1, 1'b0);
      cycle();
      drive(4'b0110, 8'b11_10_01_00, 1'b0, 1'b0);
      for (int c = 0; c < 3; c++) begin
         cycle();
         check_eq("t3 hold tag", bus.res_tag, 64'd11);
         check_eq("t3 hold data", bus.res_data, exp_t2[1]);
         check_eq("t3 busy", busy, 1'b1);
         check_eq("t3 no grant", bus.req_ready, '0);
      end
      drive(4'b0110, 8'b11_10_01_00, 1'b1, 1'b0);
      #1 check_eq("t3 grant", bus.req_ready, 4'b0100);
      cycle();
      check_eq("t3 reload valid", bus.res_valid, 1'b1);
      check_eq("t3 reload tag", bus.res_tag, 64'd12);

      // Test 4: flush with a held result and requester 3 valid
      drive(4'b1000, 8'b11_10_01_00, 1'b0, 1'b1);
      #1 check_eq("t4 flush grant", bus.req_ready, '0);
      cycle();
      check_eq("t4 res_valid", bus.res_valid, 1'b0);
      check_eq("t4 issue_cnt", issue_cnt, 64'd7);
      drive(4'b1000, 8'b11_10_01_00, 1'b1, 1'b0);
      #1 check_eq("t4 ptr kept", bus.req_ready, 4'b1000);
      cycle();

      // Test 5: asynchronous reset between edges
      check_eq("t5 pre valid", bus.res_valid, 1'b1);
      #2 reset = 1'b1;
      #1;
      check_eq("t5 res_valid", bus.res_valid, 1'b0);
      check_eq("t5 res_data", bus.res_data, '0);
      check_eq("t5 res_tag", bus.res_tag, '0);
      check_eq("t5 issue_cnt", issue_cnt, '0);
      check_eq("t5 req_ready", bus.req_ready, '0);
      model_clear();
      @(posedge clk);
      #1 reset = 1'b0;
      drive(4'b1111, 8'b11_10_01_00, 1'b1, 1'b0);
      #1 check_eq("t5 ptr zero", bus.req_ready, 4'b0001);

      // Test 6: counter saturation
      for (int c = 0; c < CNT_MAX + 6; c++) cycle();
      check_eq("t6 saturated", issue_cnt, 64'(CNT_MAX));
      cycle();
      check_eq("t6 stays", issue_cnt, 64'(CNT_MAX));

      // Randomized traffic against the model
      do_reset();
      for (int c = 0; c < 400; c++) begin
         set_random_operands();
         drive(NUM_REQ'($urandom_range(0, (1 << NUM_REQ) - 1)), (2*NUM_REQ)'($urandom),
               ($urandom_range(0, 9) < 7), ($urandom_range(0, 11) == 0));
         cycle();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
`default_nettype wire

// File: doc/logic_fu_arbiter.md
Name: logic_fu_arbiter

Overview:
- Shares one 64-bit bitwise logic functional unit (AND/OR/XOR/NOR) among NUM_REQ reservation-station requesters.
- Grants one requester per cycle using round-robin priority.
- Computes the selected operation and holds the result, with its ROB tag, in a one-entry output register under a valid/ready handshake to the writeback/CDB arbiter.
- Supports pipeline flush and provides a saturating issue counter for performance monitoring.

Parameters:
- NUM_REQ, 4, number of requesting reservation stations (2..8)
- WIDTH, 64, operand/result width in bits
- TAG_W, 6, ROB tag width
- CNT_W, 16, width of saturating issue counter

Ports:
- clk  input  1  single clock; all state on rising edge
- reset  input  1  asynchronous, active-high reset
- req_valid  input  NUM_REQ  per-requester request valid
- req_ready  output  NUM_REQ  one-hot grant; transfer when req_valid[i] && req_ready[i]
- req_op  input  2*NUM_REQ  op per requester, slice [2i+1:2i]: 00 AND, 01 OR, 10 XOR, 11 NOR
- req_a  input  WIDTH*NUM_REQ  operand A per requester, slice [WIDTH*i +: WIDTH]
- req_b  input  WIDTH*NUM_REQ  operand B per requester
- req_tag  input  TAG_W*NUM_REQ  ROB tag per requester
- flush  input  1  squash: discard held result, block issue this cycle
- res_valid  output  1  result register holds valid result
- res_ready  input  1  downstream accepts result
- res_data  output  WIDTH  result value
- res_tag  output  TAG_W  ROB tag of result
- busy  output  1  res_valid && !res_ready (unit stalled)
- issue_cnt  output  CNT_W  saturating count of accepted requests

Behaviour:
- Reset (async, immediate): res_valid=0, res_data=0, res_tag=0, rr_ptr=0, issue_cnt=0.
- accept_en = !flush && (!res_valid || res_ready).
- req_ready is combinational. It is zero unless accept_en. When accept_en, it is one-hot on the first i with req_valid[i]=1, searching i = rr_ptr, rr_ptr+1, …, wrapping modulo NUM_REQ. If no requester is valid, all bits are 0.
- req_ready never depends on req_valid of a requester other than through the priority search. No combinational path from res_data to req_ready.
- Latency: a request accepted in cycle N presents res_valid=1 with its result in cycle N+1. Throughput is 1 per cycle when res_ready is held high.
- Compute, registered on accept: res_data = a&b, a|b, a^b, or ~(a|b) per op. res_tag = granted tag.
- Pointer update on accept of requester g: rr_ptr <= (g+1) mod NUM_REQ. rr_ptr is held when nothing is accepted.
- Output register update, by priority:
  - flush=1 → res_valid<=0 (data/tag don't-care).
  - Else accept → res_valid<=1 with new data.
  - Else res_valid && res_ready → res_valid<=0.
  - Else hold.
- Stall: while res_valid && !res_ready, res_data/res_tag are stable and req_ready=0.
- Simultaneous drain and accept: the old result leaves and the new result loads in the same edge, with no bubble.
- issue_cnt increments by 1 per accept and saturates at 2^CNT_W-1. It is not cleared by flush.
- Reset mid-operation: an in-flight result is lost. No req_ready is asserted while reset is high.
- NUM_REQ=1 degenerates to a pass-through register, with rr_ptr constant 0.

Test Plan:
1. Reset, then only requester 0 valid: op=11, a=0x5555…55, b=0xAAAA…AA, tag=5, res_ready=1 → next cycle res_valid=1, res_data=0x0000…00, res_tag=5; issue_cnt=1.
2. All 4 requesters valid continuously, res_ready=1 → grants cycle 0,1,2,3,0,…; back-to-back res_valid; ops 00/01/10/11 on a=0xFF00…FF00, b=0x0F0F…0F → results 0x0F00…0F00, 0xFF0F…FF0F, 0xF00F…F00F, 0x00F0…00F0.
3. res_ready=0 for 3 cycles with requesters 1 and 2 valid → one result held stable, busy=1, req_ready=0. Raise res_ready → same-edge drain+accept, requester 2 granted next (rr_ptr=2).
4. flush asserted with res_valid=1 and requester 3 valid → next cycle res_valid=0, no grant in flush cycle, rr_ptr unchanged, issue_cnt unchanged.
5. Assert reset mid-stream with res_valid=1 → res_valid, res_data, issue_cnt, rr_ptr = 0 immediately without clock edge.
6. Force issue_cnt to 0xFFFE, accept 3 requests → issue_cnt reads 0xFFFF and stays.
